// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   UART-side program loader for the pipelined MIPS. Bytes from the UART
//   receiver are assembled big-endian into 32-bit words and written to
//   instruction memory from word address 0 upward. The load ends on the halt
//   word (which is itself written) or when memory is full; the CPU is held in
//   stall until then.
//
//   Optional build macro: LOADER_CHECKSUM_EN
//     When defined, an 8-bit XOR of all accepted bytes is kept and one extra
//     checksum byte is expected after the halt word. A mismatch sets load_err.
//     When undefined, load_err flags only a memory overflow.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active low
//   rx_byte     in   [7:0] received byte, valid with rx_done
//   rx_done     in   one-cycle byte strobe
//   imem_wr_en  out  instruction memory write strobe, one cycle per word
//   imem_addr   out  [ADDR_W-1:0] word address of the write
//   imem_wdata  out  [31:0] assembled word
//   word_count  out  [ADDR_W:0] number of words written so far
//   load_done   out  high from end of load until reset
//   cpu_enable  out  releases the pipeline; same as load_done
//   load_err    out  sticky error flag (overflow / checksum mismatch)
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int          ADDR_W         = 10,
  parameter int          MAX_WORDS      = 1024,
  parameter logic [31:0] HALT_WORD      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              cpu_enable,
  output logic              load_err
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_ASSEMBLE = 2'd0,
    S_WRITE    = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK    = 2'd2,
`endif
    S_DONE     = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       shift_reg, shift_next;
  logic [1:0]        idx_reg, idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [TO_W-1:0]   timer_reg, timer_next;
  logic              err_reg, err_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_reg, xor_next;
`endif

  logic is_halt;
  logic at_last;
  logic byte_take;

  assign is_halt = (shift_reg == HALT_WORD);
  assign at_last = (addr_reg == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_ASSEMBLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ASSEMBLE: begin
        if (rx_done && (idx_reg == 2'd3)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          // A byte arriving in the halt write cycle is the checksum byte.
          state_next = rx_done ? S_DONE : S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else if (at_last) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ASSEMBLE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_done) begin
          state_next = S_DONE;
        end
      end
`endif
      S_DONE:  state_next = S_DONE;
      default: state_next = S_ASSEMBLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  // Bytes are taken while assembling, and also during a WRITE that returns to
  // ASSEMBLE, so a back-to-back stream never loses the byte after a word.
  assign byte_take = rx_done &&
                     ((state_reg == S_ASSEMBLE) ||
                      ((state_reg == S_WRITE) && (state_next == S_ASSEMBLE)));

  always_comb begin
    shift_next = shift_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
`ifdef LOADER_CHECKSUM_EN
    xor_next   = xor_reg;
`endif

    if (byte_take) begin
      shift_next = {shift_reg[23:0], rx_byte};
      idx_next   = idx_reg + 2'd1;
      timer_next = '0;
`ifdef LOADER_CHECKSUM_EN
      xor_next   = xor_reg ^ rx_byte;
`endif
    end else if ((state_reg == S_ASSEMBLE) && (idx_reg != 2'd0)) begin
      // Stalled partial word: drop it once the idle limit is reached.
      if (timer_reg == TO_LAST) begin
        idx_next   = 2'd0;
        timer_next = '0;
      end else begin
        timer_next = timer_reg + TO_ONE;
      end
    end

    if (state_reg == S_WRITE) begin
      addr_next  = addr_reg + ADDR_ONE;
      count_next = count_reg + CNT_ONE;
      if (!is_halt && at_last) begin
        err_next = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (is_halt && rx_done) begin
        err_next = (rx_byte != xor_reg);
      end
`endif
    end

`ifdef LOADER_CHECKSUM_EN
    if ((state_reg == S_CHECK) && rx_done) begin
      err_next = (rx_byte != xor_reg);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      count_reg <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_reg   <= '0;
`endif
    end else begin
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
`ifdef LOADER_CHECKSUM_EN
      xor_reg   <= xor_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_wr_en = (state_reg == S_WRITE);
    load_done  = (state_reg == S_DONE);
    cpu_enable = (state_reg == S_DONE);
    imem_addr  = addr_reg;
    imem_wdata = shift_reg;
    word_count = count_reg;
    load_err   = err_reg;
  end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed bench for instr_loader. Two instances share the byte stream:
//   u_dut (1024 words) and u_ovf (4 words) for the overflow case. Both use a
//   short idle timeout so the timeout case stays brief.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_done = 1'b0;

  logic          m_wr_en, m_done, m_cpu, m_err;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [AW:0]   m_count;

  logic          o_wr_en, o_done, o_cpu, o_err;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_wdata;
  logic [AW:0]   o_count;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] m_log_addr[$];
  logic [31:0]   m_log_data[$];
  logic [AW-1:0] o_log_addr[$];
  logic [31:0]   o_log_data[$];

  always #5 clk = ~clk;

  instr_loader #(
    .ADDR_W(AW), .MAX_WORDS(1024), .HALT_WORD(32'h0), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done),
    .imem_wr_en(m_wr_en), .imem_addr(m_addr), .imem_wdata(m_wdata),
    .word_count(m_count), .load_done(m_done), .cpu_enable(m_cpu),
    .load_err(m_err)
  );

  instr_loader #(
    .ADDR_W(AW), .MAX_WORDS(4), .HALT_WORD(32'h0), .TIMEOUT_CYCLES(TO)
  ) u_ovf (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done),
    .imem_wr_en(o_wr_en), .imem_addr(o_addr), .imem_wdata(o_wdata),
    .word_count(o_count), .load_done(o_done), .cpu_enable(o_cpu),
    .load_err(o_err)
  );

  // Write capture, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_wr_en) begin
      m_log_addr.push_back(m_addr);
      m_log_data.push_back(m_wdata);
      $display("dut write addr=%0d data=%08h", m_addr, m_wdata);
    end
    if (o_wr_en) begin
      o_log_addr.push_back(o_addr);
      o_log_data.push_back(o_wdata);
      $display("ovf write addr=%0d data=%08h", o_addr, o_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; consecutive calls give back-to-back bytes.
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  // Sends a word MSB first; no idle after the last byte, so on return the
  // DUT is in its WRITE cycle.
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i < 3) idle(gap);
    end
  endtask

  task automatic clear_logs();
    m_log_addr.delete();
    m_log_data.delete();
    o_log_addr.delete();
    o_log_data.delete();
  endtask

  task automatic do_reset();
    rx_done = 1'b0;
    rst = 1'b0;
    idle(3);
    clear_logs();
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle(3);
    check("rst_wr_en", {31'd0, m_wr_en}, 32'd0);
    check("rst_addr", {22'd0, m_addr}, 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_count", {21'd0, m_count}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    check("rst_cpu", {31'd0, m_cpu}, 32'd0);
    check("rst_err", {31'd0, m_err}, 32'd0);
    clear_logs();
    rst = 1'b1;

    // ---------------- T1: basic load, spaced bytes ----------------
    send_word(32'h2008_0005, 1);
    idle(1);
    send_word(32'h0000_0000, 1);
    check("t1_halt_wr_en", {31'd0, m_wr_en}, 32'd1);
    check("t1_done_during_wr", {31'd0, m_done}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h2D);
`else
    idle(1);
`endif
    check("t1_done", {31'd0, m_done}, 32'd1);
    check("t1_cpu", {31'd0, m_cpu}, 32'd1);
    check("t1_wr_en_off", {31'd0, m_wr_en}, 32'd0);
    check("t1_nwrites", m_log_data.size(), 32'd2);
    check("t1_addr0", {22'd0, m_log_addr[0]}, 32'd0);
    check("t1_data0", m_log_data[0], 32'h2008_0005);
    check("t1_addr1", {22'd0, m_log_addr[1]}, 32'd1);
    check("t1_data1", m_log_data[1], 32'h0000_0000);
    check("t1_count", {21'd0, m_count}, 32'd2);
    check("t1_err", {31'd0, m_err}, 32'd0);
    // Bytes after DONE are ignored.
    send_word(32'h1111_1111, 0);
    idle(2);
    check("t1_ignored", m_log_data.size(), 32'd2);

    // ---------------- T2: timeout drops partial word ----------------
    do_reset();
    send_byte(8'h12);
    idle(1);
    send_byte(8'h34);
    idle(TO);
    send_word(32'hAABB_CCDD, 1);
    idle(1);
    send_word(32'h0000_0000, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h26);
`else
    idle(1);
`endif
    idle(1);
    check("t2_nwrites", m_log_data.size(), 32'd2);
    check("t2_addr0", {22'd0, m_log_addr[0]}, 32'd0);
    check("t2_data0", m_log_data[0], 32'hAABB_CCDD);
    check("t2_data1", m_log_data[1], 32'h0000_0000);
    check("t2_done", {31'd0, m_done}, 32'd1);

    // ---------------- T3: back-to-back bytes ----------------
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    idle(2);
    check("t3_nwrites", m_log_data.size(), 32'd2);
    check("t3_data0", m_log_data[0], 32'h0102_0304);
    check("t3_addr1", {22'd0, m_log_addr[1]}, 32'd1);
    check("t3_data1", m_log_data[1], 32'h0506_0708);
    check("t3_count", {21'd0, m_count}, 32'd2);
    check("t3_not_done", {31'd0, m_done}, 32'd0);

    // ---------------- T4: overflow on 4-word instance ----------------
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
    check("t4_last_wr_en", {31'd0, o_wr_en}, 32'd1);
    check("t4_done_during_wr", {31'd0, o_done}, 32'd0);
    idle(1);
    check("t4_done", {31'd0, o_done}, 32'd1);
    check("t4_err", {31'd0, o_err}, 32'd1);
    check("t4_count", {21'd0, o_count}, 32'd4);
    check("t4_nwrites", o_log_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_addr%0d", i), {22'd0, o_log_addr[i]}, i);
    end
    check("t4_data0", o_log_data[0], 32'h1011_1213);
    check("t4_data3", o_log_data[3], 32'h1C1D_1E1F);
    for (int i = 0; i < 4; i++) send_byte(8'h77);
    idle(2);
    check("t4_no_more_writes", o_log_data.size(), 32'd4);
    check("t4_count_frozen", {21'd0, o_count}, 32'd4);

    // ---------------- T5: reset mid-load ----------------
    do_reset();
    send_word(32'hA1A2_A3A4, 0);
    send_word(32'hB1B2_B3B4, 0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    rst = 1'b0;
    idle(1);
    check("t5_rst_wr_en", {31'd0, m_wr_en}, 32'd0);
    check("t5_rst_addr", {22'd0, m_addr}, 32'd0);
    check("t5_rst_wdata", m_wdata, 32'd0);
    check("t5_rst_count", {21'd0, m_count}, 32'd0);
    check("t5_rst_cpu", {31'd0, m_cpu}, 32'd0);
    idle(1);
    clear_logs();
    rst = 1'b1;
    send_word(32'h1122_3344, 1);
    idle(1);
    check("t5_cpu_mid", {31'd0, m_cpu}, 32'd0);
    send_word(32'h0000_0000, 1);
    check("t5_cpu_at_halt_wr", {31'd0, m_cpu}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44);
`else
    idle(1);
`endif
    check("t5_cpu_after", {31'd0, m_cpu}, 32'd1);
    check("t5_nwrites", m_log_data.size(), 32'd2);
    check("t5_addr0", {22'd0, m_log_addr[0]}, 32'd0);
    check("t5_data0", m_log_data[0], 32'h1122_3344);
    check("t5_data1", m_log_data[1], 32'h0000_0000);

`ifdef LOADER_CHECKSUM_EN
    // ---------------- T6: checksum good / bad ----------------
    do_reset();
    send_word(32'h0102_0304, 1);
    idle(1);
    send_word(32'h0000_0000, 1);
    idle(2);
    check("t6_wait_check", {31'd0, m_done}, 32'd0);
    send_byte(8'h04);
    idle(1);
    check("t6_good_done", {31'd0, m_done}, 32'd1);
    check("t6_good_err", {31'd0, m_err}, 32'd0);
    do_reset();
    send_word(32'h0102_0304, 1);
    idle(1);
    send_word(32'h0000_0000, 1);
    idle(2);
    send_byte(8'h05);
    idle(1);
    check("t6_bad_done", {31'd0, m_done}, 32'd1);
    check("t6_bad_err", {31'd0, m_err}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- UART-side program loader for the pipelined MIPS; the inbound counterpart of the debug dump path.
- Takes bytes from the UART receiver, assembles them into 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Stops on the halt word or when memory is full, then enables the CPU.
- Holds the CPU in stall (cpu_enable=0) for the whole load.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- MAX_WORDS, 1024, word capacity of instruction memory (must be <= 2**ADDR_W).
- HALT_WORD, 32'h0000_0000, word value that terminates the load.
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of one word before the partial word is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rx_byte  in  8  received byte from UART receiver, valid when rx_done=1
- rx_done  in  1  one-cycle strobe, byte available
- imem_wr_en  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  assembled instruction word
- word_count  out  ADDR_W+1  number of words written so far
- load_done  out  1  high from end of load until reset
- cpu_enable  out  1  releases the MIPS pipeline; equals load_done
- load_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (rst=0 at a clk edge) clears all outputs to 0, byte index to 0, timeout counter to 0, and sets state to ASSEMBLE.
  - Reset mid-load aborts the load; memory already written is not erased.
  - After reset the next byte is byte 0 of word 0.
- Byte order is big-endian: the first byte of a word goes to [31:24], the fourth to [7:0].
- ASSEMBLE state:
  - Each rx_done shifts rx_byte into the shift register and increments the 2-bit byte index.
  - On the 4th byte, go to WRITE.
- WRITE state (one cycle; the clock after the 4th rx_done):
  - imem_wr_en=1, imem_addr=current address, imem_wdata=assembled word.
  - At the end of the cycle, address and word_count increment.
  - Next state:
    - DONE if word==HALT_WORD, or if the written address was MAX_WORDS-1.
    - CHECK if LOADER_CHECKSUM_EN is defined and the word was the halt word.
    - Otherwise ASSEMBLE.
  - The halt word is always written so the CPU stops on it.
  - If rx_done arrives during WRITE it is accepted as byte 0 of the next word; no byte is lost.
- Latency: 4th rx_done at cycle N gives imem_wr_en at cycle N+1.
- Timeout:
  - The counter runs only while byte index != 0 in ASSEMBLE.
  - On reaching TIMEOUT_CYCLES-1 the partial word is discarded and the index returns to 0; the address is unchanged.
  - rx_done in the same cycle as expiry wins: the byte is accepted and the counter reloads to 0.
- Overflow: when MAX_WORDS words have been written without a halt word, the load ends in DONE and load_err=1.
- DONE state: load_done=1 and cpu_enable=1 (registered, asserted the cycle after the final write). All further rx_done are ignored and no further writes occur until reset.
- imem_wr_en is never high outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every accepted byte, including the halt word's bytes.
  - After the halt write, the state goes to CHECK and waits for one more byte.
  - If that byte equals the XOR, go to DONE with load_err=0; otherwise go to DONE with load_err=1.
  - The timeout does not apply in CHECK.
  - The CPU is enabled either way.
- Not defined: there is no CHECK state, and load_err is set only on overflow.

Test Plan:
- Send bytes 20 08 00 05, then 00 00 00 00 → write addr0=0x20080005, then addr1=0x00000000; load_done=1 one cycle after the second write; word_count=2; load_err=0.
- Send 12 34, idle TIMEOUT_CYCLES clocks, then AA BB CC DD 00 00 00 00 → no write of 0x1234xxxx; addr0=0xAABBCCDD; addr1=halt.
- Back-to-back rx_done every cycle for 8 bytes 01..08 → writes 0x01020304 at addr0 and 0x05060708 at addr1; no byte dropped during the WRITE cycle.
- MAX_WORDS=4 with no halt, 16 nonzero bytes → 4 writes at addr 0..3, then load_done=1, load_err=1; a 17th byte causes no write.
- Assert rst=0 after 2 full words plus 2 bytes, release, then send 11 22 33 44 00 00 00 00 → outputs zero during reset; new write at addr0=0x11223344; cpu_enable=0 until the halt write.
- With LOADER_CHECKSUM_EN: send 01 02 03 04 00 00 00 00 then 04 → load_err=0. Repeat with final byte 05 → load_err=1; load_done=1 in both cases.
